counter_ctrl: RTL and testbench

- Sequencing controller placed directly upstream of the 8-bit loadable up-counter.
- Drives the counter's load, en and data_in, and reads back its cnt output.
- Provides start/stop/pause control, a programmable enable prescaler, terminal-count detection, one-shot or auto-reload operation, and a completed-period tally.

---
 rtl/counter_ctrl_if.sv | 30 +++
 rtl/counter_ctrl.sv | 92 +++++++++
 tb/tb_counter_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between counter_ctrl and its environment (host pins plus counter feedback).
interface counter_ctrl_if #(
  parameter int W  = 8,
  parameter int PW = 8
);
  logic          start;
  logic          stop;
  logic          pause;
  logic          auto_reload;
  logic [PW-1:0] prescale;
  logic [W-1:0]  reload_val;
  logic [W-1:0]  term_val;
  logic [W-1:0]  cnt;
  logic          load;
  logic          en;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          done;
  logic [7:0]    periods;

  modport master (
    input  start, stop, pause, auto_reload, prescale, reload_val, term_val, cnt,
    output load, en, data_in, busy, done, periods
  );

  modport slave (
    output start, stop, pause, auto_reload, prescale, reload_val, term_val, cnt,
    input  load, en, data_in, busy, done, periods
  );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for an external 8-bit loadable up-counter: load, prescaled enable,
// terminal detect, one-shot/auto-reload and a saturating period tally.
module counter_ctrl #(
  parameter int W  = 8,
  parameter int PW = 8
) (
  input logic            clk,
  input logic            rst,
  counter_ctrl_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state, state_nx;
  logic [PW-1:0] pre_cnt, prescale_r;
  logic [W-1:0]  reload_r, term_r;
  logic          auto_r;
  logic          done_r;
  logic [7:0]    periods_r;
  logic          load_c, en_c;
  logic          tick, term, accept;

  assign tick   = (pre_cnt == prescale_r);
  assign term   = (bus.cnt == term_r);
  assign accept = (state == S_IDLE) && bus.start && !bus.stop;

  // stop has the highest priority in every busy state
  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    en_c     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_LOAD;
      S_LOAD: begin
        load_c   = !bus.stop;
        state_nx = bus.stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.stop)       state_nx = S_IDLE;
        else if (term)      state_nx = auto_r ? S_LOAD : S_IDLE;
        else if (bus.pause) state_nx = S_HOLD;
        else                en_c     = tick;
      end
      S_HOLD: begin
        if (bus.stop)        state_nx = S_IDLE;
        else if (!bus.pause) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      prescale_r <= '0;
      reload_r   <= '0;
      term_r     <= '0;
      auto_r     <= 1'b0;
      done_r     <= 1'b0;
      periods_r  <= '0;
    end else begin
      state  <= state_nx;
      done_r <= 1'b0;
      if (accept) begin
        prescale_r <= bus.prescale;
        reload_r   <= bus.reload_val;
        term_r     <= bus.term_val;
        auto_r     <= bus.auto_reload;
      end
      if (state == S_LOAD) pre_cnt <= '0;
      if (state == S_RUN && !bus.stop) begin
        if (term) begin
          pre_cnt <= '0;
          done_r  <= 1'b1;
          if (periods_r != 8'hFF) periods_r <= periods_r + 8'd1;
        end else if (!bus.pause) begin
          pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
      end
    end
  end

  assign bus.load    = load_c;
  assign bus.en      = en_c;
  assign bus.data_in = reload_r;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_r;
  assign bus.periods = periods_r;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural 8-bit loadable counter closing the cnt loop.
module tb_counter_ctrl;
  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_ctrl_if #(.W(8), .PW(8)) bus();

  counter_ctrl #(.W(8), .PW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the downstream counter: load beats en, wraps modulo 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bus.cnt <= '0;
    else if (bus.load) bus.cnt <= bus.data_in;
    else if (bus.en)   bus.cnt <= bus.cnt + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] rv, input logic [7:0] tv, input logic [7:0] ps, input logic ar);
    bus.reload_val  = rv;
    bus.term_val    = tv;
    bus.prescale    = ps;
    bus.auto_reload = ar;
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.load !== 1'b0)       begin n_bad++; $display("FAIL reset_load: got %b want 0", bus.load); end
    n_cmp++; if (bus.en !== 1'b0)         begin n_bad++; $display("FAIL reset_en: got %b want 0", bus.en); end
    n_cmp++; if (bus.data_in !== 8'd0)    begin n_bad++; $display("FAIL reset_data_in: got %0d want 0", bus.data_in); end
    n_cmp++; if (bus.done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.periods !== 8'd0)    begin n_bad++; $display("FAIL reset_periods: got %0d want 0", bus.periods); end
    rst = 1'b0;
    step();
  endtask

  // reload 5, term 8, prescale 0, one-shot; start in C0
  task automatic test_oneshot(input logic [7:0] exp_periods);
    cfg(8'd5, 8'd8, 8'd0, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0; #1;
    n_cmp++; if (bus.load !== 1'b1)    begin n_bad++; $display("FAIL os_c1_load: got %b want 1", bus.load); end
    n_cmp++; if (bus.data_in !== 8'd5) begin n_bad++; $display("FAIL os_c1_data_in: got %0d want 5", bus.data_in); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.en !== 1'b1)            begin n_bad++; $display("FAIL os_c%0d_en: got %b want 1", i + 2, bus.en); end
      n_cmp++; if (bus.cnt !== 8'(5 + i))      begin n_bad++; $display("FAIL os_c%0d_cnt: got %0d want %0d", i + 2, bus.cnt, 5 + i); end
    end
    step();
    n_cmp++; if (bus.cnt !== 8'd8 || bus.en !== 1'b0) begin n_bad++; $display("FAIL os_c5: got cnt=%0d en=%b want cnt=8 en=0", bus.cnt, bus.en); end
    step();
    n_cmp++; if (bus.done !== 1'b1)             begin n_bad++; $display("FAIL os_c6_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0)             begin n_bad++; $display("FAIL os_c6_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.periods !== exp_periods)   begin n_bad++; $display("FAIL os_c6_periods: got %0d want %0d", bus.periods, exp_periods); end
    n_cmp++; if (bus.cnt !== 8'd8)              begin n_bad++; $display("FAIL os_c6_cnt: got %0d want 8", bus.cnt); end
    step();
    n_cmp++; if (bus.done !== 1'b0)             begin n_bad++; $display("FAIL os_c7_done: got %b want 0", bus.done); end
  endtask

  // prescale 2: en on RUN cycles 3,6,9; cnt=3 on RUN 10; done on RUN 11
  task automatic test_prescale();
    logic [31:0] en_mask;
    int          done_r;
    en_mask = '0; done_r = -1;
    cfg(8'd0, 8'd3, 8'd2, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      step();
      if (bus.en) en_mask[r] = 1'b1;
      if (bus.done && done_r < 0) done_r = r;
      if (r == 10) begin
        n_cmp++; if (bus.cnt !== 8'd3) begin n_bad++; $display("FAIL ps_cnt_at_term: got %0d want 3", bus.cnt); end
      end
    end
    n_cmp++; if (en_mask !== 32'h0000_0248) begin n_bad++; $display("FAIL ps_en_mask: got %h want 00000248", en_mask); end
    n_cmp++; if (done_r != 11)              begin n_bad++; $display("FAIL ps_done_cycle: got %0d want 11", done_r); end
  endtask

  // prescale 3, pause in C3..C7 (pre_cnt=1 at C3): en at C11,C15 instead of C5,C9; done C17
  task automatic test_pause();
    logic [31:0] en_mask;
    int          done_c;
    int          frozen_bad;
    en_mask = '0; done_c = -1; frozen_bad = 0;
    cfg(8'd0, 8'd2, 8'd3, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) step();
      bus.pause = (c >= 3 && c <= 7);
      #1;
      if (bus.en) en_mask[c] = 1'b1;
      if (bus.done && done_c < 0) done_c = c;
      if (c >= 3 && c <= 8 && (bus.cnt !== 8'd0 || bus.en !== 1'b0)) frozen_bad++;
    end
    n_cmp++; if (frozen_bad != 0)            begin n_bad++; $display("FAIL pause_frozen: got %0d bad cycles want 0", frozen_bad); end
    n_cmp++; if (en_mask !== 32'h0000_8800)  begin n_bad++; $display("FAIL pause_en_mask: got %h want 00008800", en_mask); end
    n_cmp++; if ($countones(en_mask) != 2)   begin n_bad++; $display("FAIL pause_en_total: got %0d want 2", $countones(en_mask)); end
    n_cmp++; if (done_c != 17)               begin n_bad++; $display("FAIL pause_done_cycle: got %0d want 17", done_c); end
  endtask

  task automatic test_abort(input logic [7:0] p_before);
    int done_seen;
    int done_c;
    logic [7:0] cnt_at_done;
    done_seen = 0;
    // stop in RUN
    cfg(8'd10, 8'd200, 8'd0, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    step(); bus.stop = 1'b1; #1;
    n_cmp++; if (bus.en !== 1'b0 || bus.load !== 1'b0) begin n_bad++; $display("FAIL stop_same_cycle: got en=%b load=%b want 0 0", bus.en, bus.load); end
    step(); bus.stop = 1'b0; #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_idle: got busy=%b want 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      if (bus.done) done_seen++;
      step();
    end
    n_cmp++; if (done_seen != 0)          begin n_bad++; $display("FAIL stop_no_done: got %0d want 0", done_seen); end
    n_cmp++; if (bus.periods !== p_before) begin n_bad++; $display("FAIL stop_periods: got %0d want %0d", bus.periods, p_before); end
    // start with stop in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    step(); bus.start = 1'b0; bus.stop = 1'b0; #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.load !== 1'b0) begin n_bad++; $display("FAIL start_stop_idle: got busy=%b load=%b want 0 0", bus.busy, bus.load); end
    // start while busy is ignored, captured config kept (term 5 -> done at C8)
    cfg(8'd0, 8'd5, 8'd0, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    step(); cfg(8'd100, 8'd200, 8'd1, 1'b1); bus.start = 1'b1;
    step(); bus.start = 1'b0;
    done_c = -1; cnt_at_done = '0;
    for (int c = 4; c <= 20 && done_c < 0; c++) begin
      if (c > 4) step();
      if (bus.done) begin done_c = c; cnt_at_done = bus.cnt; end
    end
    n_cmp++; if (done_c != 8)           begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d want 8", done_c); end
    n_cmp++; if (cnt_at_done !== 8'd5)  begin n_bad++; $display("FAIL busy_start_cnt: got %0d want 5", cnt_at_done); end
    n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL busy_start_oneshot: got busy=%b want 0", bus.busy); end
    n_cmp++; if (bus.data_in !== 8'd0)  begin n_bad++; $display("FAIL busy_start_reload: got %0d want 0", bus.data_in); end
    n_cmp++; if (bus.periods !== 8'(p_before + 1)) begin n_bad++; $display("FAIL busy_start_periods: got %0d want %0d", bus.periods, p_before + 1); end
    step();
  endtask

  // 250 -> 2 with wrap: LOAD + 9 RUN cycles per period
  task automatic test_auto_wrap();
    int   c, dones, d1, d2, consec;
    logic prev_done;
    logic [7:0] p1, p2;
    c = 1; dones = 0; d1 = -1; d2 = -1; consec = 0; prev_done = 1'b0; p1 = '0; p2 = '0;
    cfg(8'd250, 8'd2, 8'd0, 1'b1);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    while (dones < 300 && c < 3500) begin
      step(); c++;
      if (c == 8) begin
        n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt_zero: got %0d want 0", bus.cnt); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.cnt !== 8'd2) begin n_bad++; $display("FAIL wrap_cnt_term: got %0d want 2", bus.cnt); end
      end
      if (c == 11) begin
        n_cmp++; if (bus.load !== 1'b1 || bus.data_in !== 8'd250) begin n_bad++; $display("FAIL wrap_reload: got load=%b data_in=%0d want 1 250", bus.load, bus.data_in); end
      end
      if (bus.done && prev_done) consec++;
      prev_done = bus.done;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin d1 = c; p1 = bus.periods; end
        if (dones == 2) begin d2 = c; p2 = bus.periods; end
      end
    end
    n_cmp++; if (dones != 300)          begin n_bad++; $display("FAIL wrap_timeout: got %0d dones want 300", dones); end
    n_cmp++; if (d2 - d1 != 10)         begin n_bad++; $display("FAIL wrap_spacing: got %0d want 10", d2 - d1); end
    n_cmp++; if (p2 !== 8'(p1 + 1))     begin n_bad++; $display("FAIL wrap_periods_inc: got %0d want %0d", p2, p1 + 1); end
    n_cmp++; if (consec != 0)           begin n_bad++; $display("FAIL wrap_done_consec: got %0d want 0", consec); end
    n_cmp++; if (bus.periods !== 8'd255) begin n_bad++; $display("FAIL wrap_saturate: got %0d want 255", bus.periods); end
    bus.stop = 1'b1;
    step(); bus.stop = 1'b0; #1;
    n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL wrap_stop: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    cfg(8'd5, 8'd8, 8'd0, 1'b0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.en !== 1'b0 || bus.load !== 1'b0) begin n_bad++; $display("FAIL arst_outputs: got busy=%b en=%b load=%b want 0 0 0", bus.busy, bus.en, bus.load); end
    n_cmp++; if (bus.periods !== 8'd0) begin n_bad++; $display("FAIL arst_periods: got %0d want 0", bus.periods); end
    step(); rst = 1'b0;
    step();
    test_oneshot(8'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    cfg(8'd0, 8'd0, 8'd0, 1'b0);
    test_reset();
    test_oneshot(8'd1);
    test_prescale();
    test_pause();
    test_abort(8'd3);
    test_auto_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
